// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: load/store size codes,
// responder FSM state encoding and a funct3 legality helper.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH x XLEN, per-byte write enables and a
// registered read port. The read register only updates when re_i is high, so
// the last loaded word stays available for the responder's lane logic.
module dmem_ram #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned NB   = XLEN / 8
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr_i,
  input  logic [NB-1:0]   we_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            re_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // byte-lane writes and the read register share one address port
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port. Accepts one request in
// IDLE, waits WAIT_STATES cycles, then pulses rsp_ack for one cycle.
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned half/word accesses
// report an error instead of having their low address bits masked.
//
//  state     | meaning
//  DMEM_IDLE | waiting for rd_en/wr_en; latches request and loads counter
//  DMEM_WAIT | counting down wait states
//  DMEM_RESP | rsp_ack high; store commits to RAM on this cycle's edge
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 1024,
  parameter logic [XLEN-1:0] ADDR_BASE   = 32'h0050_0000,
  parameter int unsigned     WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  input  logic            req_rd_en,
  input  logic            req_wr_en,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_ack,
  output logic            rsp_err,
  output logic            stall
);

  localparam int unsigned IDXW    = $clog2(DEPTH);
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            dir_q, err_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [IDXW-1:0] idx_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q, rdata_q;

  logic [XLEN-1:0] off_full, wdata_rep, ram_dout, rdata_c;
  logic [IDXW-1:0] ram_addr;
  logic [3:0]      be_live, ram_we;
  logic [1:0]      lane;
  logic            req_any, accept, in_range, misalign, req_err;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign req_any  = req_rd_en | req_wr_en;
  assign accept   = (state_q == DMEM_IDLE) & req_any;
  assign off_full = req_addr - ADDR_BASE;
  // addresses below the base wrap to large offsets, so one compare covers both ends
  assign in_range = (off_full[XLEN-1:IDXW+2] == '0);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) & off_full[0]) |
                    ((req_funct3[1:0] == 2'b10) & (|off_full[1:0]));
  assign lane     = off_full[1:0];
`else
  assign misalign = 1'b0;
  assign lane     = (req_funct3[1:0] == 2'b01) ? {off_full[1], 1'b0} :
                    (req_funct3[1:0] == 2'b10) ? 2'b00 : off_full[1:0];
`endif

  assign req_err = ~in_range | (req_rd_en & req_wr_en) | misalign |
                   ~f3_legal(req_wr_en, req_funct3);

  // byte enables and lane-replicated store data from size and lane offset
  always_comb begin
    be_live   = 4'b1111;
    wdata_rep = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_live   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_live   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // next-state and countdown logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DMEM_IDLE: if (req_any) begin
        cnt_d   = WS_LOAD;
        state_d = (WAIT_STATES == 0) ? DMEM_RESP : DMEM_WAIT;
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DMEM_RESP;
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // state, counter, latched request and held read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        dir_q   <= req_wr_en;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        off_q   <= lane;
        idx_q   <= off_full[IDXW+1:2];
        be_q    <= be_live;
        wdata_q <= wdata_rep;
      end
      if (state_q == DMEM_RESP) rdata_q <= rdata_c;
    end
  end

  // the RAM read is issued on the accept edge so data is ready even with zero wait states
  assign ram_addr = (state_q == DMEM_IDLE) ? off_full[IDXW+1:2] : idx_q;
  assign ram_we   = ((state_q == DMEM_RESP) & dir_q & ~err_q) ? be_q : 4'b0000;

  dmem_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (wdata_q),
    .re_i    (accept & req_rd_en & ~req_wr_en & ~req_err),
    .rdata_o (ram_dout)
  );

  assign byte_sel = ram_dout[{off_q, 3'b000} +: 8];
  assign half_sel = ram_dout[{off_q[1], 4'b0000} +: 16];

  // lane select and extension; stores and errored accesses return zero
  always_comb begin
    rdata_c = '0;
    if (!err_q && !dir_q) begin
      case (f3_q)
        F3_LB:   rdata_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        F3_LBU:  rdata_c = {{(XLEN-8){1'b0}}, byte_sel};
        F3_LH:   rdata_c = {{(XLEN-16){half_sel[15]}}, half_sel};
        F3_LHU:  rdata_c = {{(XLEN-16){1'b0}}, half_sel};
        default: rdata_c = ram_dout;
      endcase
    end
  end

  assign rsp_ack   = (state_q == DMEM_RESP);
  assign rsp_err   = rsp_ack & err_q;
  assign rsp_rdata = rsp_ack ? rdata_c : rdata_q;
  assign stall     = req_any & ~rsp_ack;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array reference model predicts
// every response, a monitor pops and compares on each rsp_ack.
module tb_dmem_responder;

  localparam int unsigned WS    = 1;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0050_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_rd_en = 1'b0, req_wr_en = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_ack, rsp_err, stall;

  dmem_responder #(
    .XLEN(32), .DEPTH(DEPTH), .ADDR_BASE(BASE), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .req_rd_en(req_rd_en), .req_wr_en(req_wr_en),
    .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack), .rsp_err(rsp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    bit          chk;
    int          ack_cyc;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  logic [7:0] mem_m [4*DEPTH];

  function automatic void model(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                output logic [31:0] rdata, output bit err);
    logic [31:0] off;
    int size, a;
    off   = addr - BASE;
    err   = 0;
    rdata = '0;
    size  = 1 << f3[1:0];
    if (off >= 32'(4*DEPTH)) err = 1;
    if (rd && wr) err = 1;
    if (wr && !(f3 inside {3'd0, 3'd1, 3'd2})) err = 1;
    if (rd && !wr && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) err = 1;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (size == 2 && off[0]) err = 1;
    if (size == 4 && off[1:0] != 2'b00) err = 1;
`endif
    if (err) return;
    a = int'(off) & ~(size - 1);
    if (wr) begin
      for (int i = 0; i < size; i++) mem_m[a+i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rdata[8*i +: 8] = mem_m[a+i];
      if (!f3[2] && size < 4 && rdata[8*size-1])
        rdata = rdata | ~((32'd1 << (8*size)) - 32'd1);
    end
  endfunction

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3, input string nm,
                        input bit fix, input logic [31:0] fx_rdata, input bit fx_err);
    exp_t e;
    bit   got;
    model(rd, wr, addr, wdata, f3, e.rdata, e.err);
    if (fix) begin
      e.rdata = fx_rdata;
      e.err   = fx_err;
    end
    e.chk     = rd;
    e.ack_cyc = cyc + WS + 1;
    e.name    = nm;
    sbq.push_back(e);
    req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    req_rd_en = rd; req_wr_en = wr;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (rsp_ack) got = 1;
      else begin
        checks++;
        if (stall !== 1'b1) begin
          errors++;
          $display("FAIL %s stall_wait got %0b want 1", nm, stall);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_timeout got none want ack", nm);
    end else if (stall !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_at_ack got %0b want 0", nm, stall);
    end
    @(posedge clk); #1;
    req_rd_en = 0; req_wr_en = 0;
  endtask

  task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    logic [31:0] addr, wd;
    logic [2:0]  f3;
    bit          rd, wr;
    int          wi, r;

    // scoreboard monitor: compares every acknowledged response
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rsp_ack) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack got ack want none");
          end else begin
            exp_t e;
            e = sbq.pop_front();
            if (rsp_err !== e.err) begin
              errors++;
              $display("FAIL %s err got %0b want %0b", e.name, rsp_err, e.err);
            end else if (e.chk && rsp_rdata !== e.rdata) begin
              errors++;
              $display("FAIL %s rdata got %h want %h", e.name, rsp_rdata, e.rdata);
            end else if (cyc != e.ack_cyc) begin
              errors++;
              $display("FAIL %s ack_cycle got %0d want %0d", e.name, cyc, e.ack_cyc);
            end
          end
        end
      end
    join_none

    #12;
    chk1("reset_ack",   32'(rsp_ack), 32'd0);
    chk1("reset_err",   32'(rsp_err), 32'd0);
    chk1("reset_rdata", rsp_rdata,    32'd0);
    chk1("reset_stall", 32'(stall),   32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    // word store then load
    do_req(0, 1, BASE, 32'hDEADBEEF, 3'b010, "t1_sw", 1, 32'h0, 0);
    do_req(1, 0, BASE, 32'h0, 3'b010, "t1_lw", 1, 32'hDEADBEEF, 0);
    // byte store with sign/zero extension
    do_req(0, 1, BASE + 32'd4, 32'h11223344, 3'b010, "t2_init", 1, 32'h0, 0);
    do_req(0, 1, BASE + 32'd6, 32'hFFFFFF80, 3'b000, "t2_sb", 1, 32'h0, 0);
    do_req(1, 0, BASE + 32'd6, 32'h0, 3'b000, "t2_lb", 1, 32'hFFFFFF80, 0);
    do_req(1, 0, BASE + 32'd6, 32'h0, 3'b100, "t2_lbu", 1, 32'h00000080, 0);
    do_req(1, 0, BASE + 32'd4, 32'h0, 3'b010, "t2_lw", 1, 32'h11803344, 0);
    // half store with sign/zero extension
    do_req(0, 1, BASE + 32'd2, 32'h00008001, 3'b001, "t3_sh", 1, 32'h0, 0);
    do_req(1, 0, BASE + 32'd2, 32'h0, 3'b001, "t3_lh", 1, 32'hFFFF8001, 0);
    do_req(1, 0, BASE + 32'd2, 32'h0, 3'b101, "t3_lhu", 1, 32'h00008001, 0);
    // range, conflict and funct3 errors
    do_req(1, 0, 32'h004F_FFFC, 32'h0, 3'b010, "t4_below", 1, 32'h0, 1);
    do_req(1, 0, BASE + 32'(4*DEPTH), 32'h0, 3'b010, "t4_above", 1, 32'h0, 1);
    do_req(1, 1, BASE, 32'h0, 3'b010, "t4_rdwr", 1, 32'h0, 1);
    do_req(1, 0, BASE, 32'h0, 3'b011, "t4_badld", 1, 32'h0, 1);
    do_req(0, 1, BASE, 32'h0, 3'b100, "t4_badst", 1, 32'h0, 1);
    do_req(1, 0, BASE, 32'h0, 3'b010, "t4_unchanged", 1, 32'h8001BEEF, 0);
    // misaligned word store
`ifdef DMEM_MISALIGN_CHECK_EN
    do_req(0, 1, BASE + 32'd2, 32'h55AA55AA, 3'b010, "t5_sw_mis", 1, 32'h0, 1);
    do_req(1, 0, BASE, 32'h0, 3'b010, "t5_lw", 1, 32'h8001BEEF, 0);
`else
    do_req(0, 1, BASE + 32'd2, 32'h55AA55AA, 3'b010, "t5_sw_mis", 1, 32'h0, 0);
    do_req(1, 0, BASE, 32'h0, 3'b010, "t5_lw", 1, 32'h55AA55AA, 0);
`endif

    // reset while the store is still waiting: no ack, no write
    do_req(0, 1, BASE + 32'd8, 32'hCAFEF00D, 3'b010, "t6_init", 1, 32'h0, 0);
    req_addr = BASE + 32'd8; req_wdata = 32'h12345678; req_funct3 = 3'b010;
    req_wr_en = 1;
    @(posedge clk); #1;
    chk1("t6_stall_wait", 32'(stall), 32'd1);
    rst_n = 0; req_wr_en = 0;
    #1;
    chk1("t6_rst_stall", 32'(stall), 32'd0);
    chk1("t6_rst_ack",   32'(rsp_ack), 32'd0);
    @(posedge clk); #1;
    chk1("t6_rst_stall2", 32'(stall), 32'd0);
    chk1("t6_rst_ack2",   32'(rsp_ack), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    do_req(1, 0, BASE + 32'd8, 32'h0, 3'b010, "t6_lw_old", 1, 32'hCAFEF00D, 0);

    // known contents for the random window
    for (int k = 0; k < 20; k++) begin
      wi = (k < 16) ? k : int'(DEPTH) - 20 + k;
      do_req(0, 1, BASE + 32'(4*wi), $urandom, 3'b010, "prefill", 0, 32'h0, 0);
    end

    for (int n = 0; n < 300; n++) begin
      r  = int'($urandom_range(0, 19));
      wi = (r < 16) ? r : int'(DEPTH) - 20 + r;
      addr = BASE + 32'(4*wi) + 32'($urandom_range(0, 3));
      r = int'($urandom_range(0, 19));
      if (r == 0) addr = BASE - 32'(4 * $urandom_range(1, 4));
      if (r == 1) addr = BASE + 32'(4*DEPTH) + 32'($urandom_range(0, 15));
      r  = int'($urandom_range(0, 9));
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        f3 = wr ? 3'($urandom_range(0, 2)) : ((f3[2]) ? {2'b10, f3[0]} : {1'b0, 2'($urandom_range(0, 2))});
      wd = $urandom;
      do_req(rd, wr, addr, wd, f3, "rand", 0, 32'h0, 0);
    end

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    chk1("drain_queue", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
